// File: rtl/framebuffer_stream_reader.sv
// Framebuffer stream reader: reads a contiguous run of words from the
// framebuffer RAM read port and streams them out as an AXI-Stream master.
// Ports: clk, resetn (async, active-low); start/startAddr/length request a
// transfer; busy/done report status; readAddr/readData drive the RAM
// (registered read, 1-cycle latency); m_axis_* is the output stream.
// Optional: define FRAMEBUFFER_STREAM_READER_BYTE_SWAP_EN to reverse the
// byte order of m_axis_tdata.
module framebuffer_stream_reader #(
    parameter int MEM_SIZE  = 13,
    parameter int MEM_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [MEM_SIZE-1:0]  startAddr,
    input  logic [MEM_SIZE:0]    length,
    output logic                 busy,
    output logic                 done,
    output logic [MEM_SIZE-1:0]  readAddr,
    input  logic [MEM_WIDTH-1:0] readData,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [MEM_WIDTH-1:0] m_axis_tdata,
    output logic                 m_axis_tlast
);

    localparam int NB = MEM_WIDTH / 8;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic                  done_q;
    logic                  done_d;
    logic [MEM_SIZE-1:0]   addr_q;
    logic [MEM_SIZE:0]     len_q;
    logic [MEM_SIZE:0]     issued_q;
    logic [MEM_SIZE:0]     beats_q;
    logic                  inflight_q;
    logic [MEM_WIDTH-1:0]  fifo_q [4];
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [2:0]            count_q;
    logic [MEM_WIDTH-1:0]  head;
    logic                  issue;
    logic                  push;
    logic                  fire;
    logic                  last_beat;
    logic                  accept;

    // Occupancy plus the read still in flight bounds the FIFO, so an
    // issue can never lead to an overflow one cycle later.
    assign issue = (state_q == STREAM) && (issued_q < len_q)
                   && ((count_q + {2'b00, inflight_q}) < 3'd4);
    assign push      = inflight_q;
    assign fire      = m_axis_tvalid & m_axis_tready;
    assign last_beat = (beats_q == len_q - 1'b1);
    assign accept    = (state_q == IDLE) && start && (length != '0);

    assign busy          = (state_q == STREAM);
    assign done          = done_q;
    assign readAddr      = addr_q;
    assign m_axis_tvalid = (count_q != 3'd0);
    assign m_axis_tlast  = m_axis_tvalid && last_beat;
    assign head          = fifo_q[rd_ptr];

`ifdef FRAMEBUFFER_STREAM_READER_BYTE_SWAP_EN
    always_comb begin
        m_axis_tdata = '0;
        for (int b = 0; b < NB; b++) begin
            m_axis_tdata[8*b +: 8] = head[8*(NB-1-b) +: 8];
        end
    end
`else
    assign m_axis_tdata = head;
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (fire && last_beat) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            beats_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
            if (accept) begin
                addr_q   <= startAddr;
                len_q    <= length;
                issued_q <= '0;
                beats_q  <= '0;
            end else begin
                if (issue) begin
                    addr_q   <= addr_q + 1'b1;
                    issued_q <= issued_q + 1'b1;
                end
                if (fire) begin
                    beats_q <= beats_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr] <= readData;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_stream_reader.sv
// Directed self-checking bench for framebuffer_stream_reader with a
// behavioural registered-read RAM model.
module tb_framebuffer_stream_reader;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [12:0] startAddr = '0;
    logic [13:0] length = '0;
    logic        busy;
    logic        done;
    logic [12:0] readAddr;
    logic [15:0] readData;
    logic        tvalid;
    logic        tready = 1'b1;
    logic [15:0] tdata;
    logic        tlast;

    framebuffer_stream_reader #(.MEM_SIZE(13), .MEM_WIDTH(16)) dut (
        .clk(clk),
        .resetn(resetn),
        .start(start),
        .startAddr(startAddr),
        .length(length),
        .busy(busy),
        .done(done),
        .readAddr(readAddr),
        .readData(readData),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .m_axis_tdata(tdata),
        .m_axis_tlast(tlast)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [8192];
    always @(posedge clk) readData <= mem[readAddr];

    typedef struct packed {
        logic [15:0] d;
        logic        l;
        logic [31:0] c;
    } beat_t;

    beat_t       beats[$];
    logic [12:0] alog[$];
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_seen = 0;
    int          stall_viol = 0;
    int          max_occ = 0;
    logic        stall_prev = 1'b0;
    logic [15:0] stall_data = '0;
    logic [12:0] cur_sa = '0;
    int          c0 = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn) begin
            if (busy) begin
                int occ;
                busy_seen = 1;
                occ = int'(13'(readAddr - cur_sa)) - beats.size();
                if (occ > max_occ) max_occ = occ;
                if (alog.size() == 0 || alog[alog.size()-1] != readAddr)
                    alog.push_back(readAddr);
            end
            if (stall_prev && (!tvalid || tdata != stall_data))
                stall_viol++;
            stall_prev = tvalid && !tready;
            stall_data = tdata;
            if (tvalid && tready)
                beats.push_back('{d: tdata, l: tlast, c: cyc});
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        beats.delete();
        alog.delete();
        done_cnt  = 0;
        done_cyc  = 0;
        busy_seen = 0;
        stall_viol = 0;
        max_occ   = 0;
    endtask

    task automatic start_xfer(input logic [12:0] sa, input logic [13:0] len);
        @(posedge clk); #1;
        cur_sa    = sa;
        startAddr = sa;
        length    = len;
        start     = 1'b1;
        c0        = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc);
        for (int i = 0; i < maxc && done_cnt == 0; i++) begin
            @(posedge clk); #1;
        end
        check(tag, done_cnt, 1);
    endtask

    initial begin
        logic [15:0] sw;
        for (int k = 0; k < 8192; k++) mem[k] = 16'(k);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_addr", readAddr, 0);
        check("rst_tdata", tdata, 0);
        resetn = 1'b1;

        // basic transfer
        clear_log();
        tready = 1'b1;
        start_xfer(13'h10, 14'd8);
        wait_done("basic_done_timeout", 40);
        repeat (3) @(posedge clk);
        #1;
        check("basic_count", beats.size(), 8);
        for (int k = 0; k < 8 && k < beats.size(); k++) begin
            check($sformatf("basic_data%0d", k), beats[k].d, 32'h10 + k);
            check($sformatf("basic_last%0d", k), beats[k].l, (k == 7));
            check($sformatf("basic_cyc%0d", k), beats[k].c, c0 + 3 + k);
        end
        check("basic_done_cnt", done_cnt, 1);
        check("basic_done_cyc", done_cyc, c0 + 11);
        check("basic_busy_end", busy, 0);

        // address wrap
        clear_log();
        start_xfer(13'h1FFE, 14'd4);
        wait_done("wrap_done_timeout", 40);
        check("wrap_count", beats.size(), 4);
        check("wrap_alog_n", alog.size() >= 4, 1);
        begin
            logic [12:0] ea [4];
            ea = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
            for (int k = 0; k < 4; k++) begin
                if (k < alog.size())
                    check($sformatf("wrap_addr%0d", k), alog[k], ea[k]);
                if (k < beats.size())
                    check($sformatf("wrap_data%0d", k), beats[k].d,
                          {3'b000, ea[k]});
            end
        end
        check("wrap_last", beats.size() == 4 && beats[3].l, 1);

        // backpressure
        clear_log();
        start_xfer(13'h100, 14'd16);
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            @(posedge clk); #1;
            tready = 1'($urandom_range(0, 1));
        end
        tready = 1'b1;
        check("bp_done_cnt", done_cnt, 1);
        check("bp_count", beats.size(), 16);
        for (int k = 0; k < 16 && k < beats.size(); k++) begin
            check($sformatf("bp_data%0d", k), beats[k].d, 32'h100 + k);
            check($sformatf("bp_last%0d", k), beats[k].l, (k == 15));
        end
        check("bp_stable", stall_viol, 0);
        check("bp_occ_le4", max_occ <= 4, 1);

        // zero length
        clear_log();
        start_xfer(13'h40, 14'd0);
        repeat (6) @(posedge clk);
        #1;
        check("zero_done_cnt", done_cnt, 1);
        check("zero_done_cyc", done_cyc, c0 + 1);
        check("zero_beats", beats.size(), 0);
        check("zero_busy", busy_seen, 0);

        // reset mid-transfer
        clear_log();
        start_xfer(13'h200, 14'd20);
        for (int i = 0; i < 60 && beats.size() < 5; i++) begin
            @(posedge clk); #1;
        end
        check("mid_reached5", beats.size() >= 5, 1);
        resetn = 1'b0;
        #1;
        check("mid_tvalid", tvalid, 0);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_tlast", tlast, 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_no_done", done_cnt, 0);
        clear_log();
        start_xfer(13'h0, 14'd2);
        wait_done("post_done_timeout", 40);
        repeat (3) @(posedge clk);
        #1;
        check("post_count", beats.size(), 2);
        for (int k = 0; k < 2 && k < beats.size(); k++) begin
            check($sformatf("post_data%0d", k), beats[k].d, k);
            check($sformatf("post_last%0d", k), beats[k].l, (k == 1));
        end

        // byte order
        mem[0] = 16'hA1B2;
`ifdef FRAMEBUFFER_STREAM_READER_BYTE_SWAP_EN
        sw = 16'hB2A1;
`else
        sw = 16'hA1B2;
`endif
        clear_log();
        start_xfer(13'h0, 14'd1);
        wait_done("swap_done_timeout", 40);
        check("swap_count", beats.size(), 1);
        if (beats.size() > 0) begin
            check("swap_data", beats[0].d, sw);
            check("swap_last", beats[0].l, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/framebuffer_stream_reader.md
Name: framebuffer_stream_reader

Overview:
- Streams a contiguous run of words out of the read port of the team's dual-port framebuffer RAM as an AXI-Stream master.
- Consumes the RAM's registered read data (1-cycle latency) and decouples it from downstream backpressure with a small internal FIFO.
- Sits directly downstream of the framebuffer RAM and feeds the display/DMA path.

Parameters:
- MEM_SIZE, 13, RAM word-address width in bits (matches the RAM's readAddr width).
- MEM_WIDTH, 16, RAM word width in bits; multiple of 8.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- startAddr  in  MEM_SIZE  first word address of the transfer
- length  in  MEM_SIZE+1  number of words to stream; 0 is legal
- busy  out  1  high while a transfer is in progress
- done  out  1  one-cycle pulse when a transfer completes
- readAddr  out  MEM_SIZE  address to the RAM read port
- readData  in  MEM_WIDTH  RAM read data, valid 1 cycle after readAddr
- m_axis_tvalid  out  1  stream data valid
- m_axis_tready  in  1  stream consumer ready
- m_axis_tdata  out  MEM_WIDTH  stream data
- m_axis_tlast  out  1  marks the final word of the transfer

Behaviour:
- Reset (resetn low, asynchronous): state IDLE. busy=0, done=0, m_axis_tvalid=0, m_axis_tlast=0, readAddr=0, m_axis_tdata=0. FIFO is emptied and the in-flight tracker is cleared. Reset mid-transfer aborts the transfer; no done pulse is generated.
- State IDLE:
  - start=1 with length>0: latch startAddr and length, go to STREAM; busy=1 from the next cycle.
  - start=1 with length=0: stay IDLE; done=1 for exactly one cycle in the next cycle; no beats are produced.
- State STREAM, issue side:
  - A read is issued in any cycle where issued<length and (FIFO occupancy + in-flight reads) < 4.
  - On issue, readAddr holds the issued address; the address register increments after the issue.
  - Addresses wrap modulo 2^MEM_SIZE: 2^MEM_SIZE-1 is followed by 0.
  - readData is pushed into the FIFO exactly one cycle after the issue.
- FIFO and stream side:
  - FIFO depth is 4 and it must never overflow.
  - m_axis_tvalid = FIFO not empty; m_axis_tdata = FIFO head.
  - A beat transfers when tvalid & tready.
  - m_axis_tvalid and m_axis_tdata must remain stable while tvalid=1 and tready=0.
  - Push and pop in the same cycle are legal; occupancy is unchanged.
- Latency: start accepted in cycle N → first readAddr in cycle N+1 → first tvalid in cycle N+3.
- Throughput: with tready held high, one beat per cycle after the first.
- m_axis_tlast=1 only on the beat whose index is length-1.
- Completion: the cycle after the final beat transfers, go to IDLE with busy=0 and done=1 for one cycle.
- start while busy=1 is ignored.
- A start in the same cycle that done is high is accepted.

Optional Feature:
- Macro FRAMEBUFFER_STREAM_READER_BYTE_SWAP_EN.
- Defined: m_axis_tdata is the FIFO head with byte order reversed (byte 0 ↔ byte MEM_WIDTH/8-1, and so on). Latency and handshake are unchanged.
- Undefined: m_axis_tdata equals the FIFO head unchanged.

Test Plan:
- Basic transfer: RAM preloaded mem[k]=k; start, startAddr=0x10, length=8, tready=1 → tdata 0x10..0x17 on consecutive cycles; tlast only on 0x17; first tvalid 3 cycles after start; done one cycle after the last beat.
- Address wrap: startAddr=0x1FFE, length=4 (MEM_SIZE=13) → readAddr sequence 0x1FFE, 0x1FFF, 0x0000, 0x0001; data in the same order.
- Backpressure: length=16, tready toggled 1,0,0,1,… pseudo-randomly → all 16 words delivered in order with none lost or duplicated; tdata stable while stalled; FIFO never exceeds 4 entries.
- Zero length: start with length=0 → no tvalid; done pulses once; busy stays 0.
- Reset mid-transfer: drop resetn after 5 of 20 beats → tvalid, busy and done go to 0 immediately. After release, a new transfer startAddr=0, length=2 yields exactly 2 correct beats.
- Byte swap: with the macro defined and mem[0]=0xA1B2, length=1 → tdata=0xB2A1. Without the macro → tdata=0xA1B2.
